// File: rtl/hazard_tracker.sv
// hazard_tracker: stall/forward controller for the MIPS pipeline.
// Keeps a shift register of in-flight destination records for every stage
// after D plus a multiply/divide busy counter, and tells D whether to stall
// and which stage forwards each source operand.
module hazard_tracker #(
  parameter int unsigned STAGES   = 3,
  parameter int unsigned AW       = 5,
  parameter int unsigned TW       = 2,
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10,
  parameter int unsigned SW       = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] d_rs,
  input  logic [AW-1:0] d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic          d_wen,
  input  logic [AW-1:0] d_dst,
  input  logic [TW-1:0] d_tnew,
  input  logic [1:0]    d_md_start,
  input  logic          d_md_use,
  output logic          stall,
  output logic [SW-1:0] fwd_rs_sel,
  output logic [SW-1:0] fwd_rt_sel,
  output logic          md_busy
);

  localparam int unsigned MD_MAX = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int unsigned MDW    = $clog2(MD_MAX + 1);

  // Record k (1 = E) lives at index k-1.
  logic [STAGES-1:0] wen_q;
  logic [AW-1:0]     dst_q  [STAGES];
  logic [TW-1:0]     tnew_q [STAGES];
  logic              md_flag_q;
  logic [MDW-1:0]    md_cnt_q;

  logic [AW-1:0] src    [2];
  logic [TW-1:0] tuse   [2];
  logic [1:0]    found;
  logic [SW-1:0] hit_k  [2];
  logic [TW-1:0] hit_t  [2];
  logic [1:0]    op_stall;
  logic [SW-1:0] op_sel [2];
  logic          md_stall;
  logic          md_start_mult;
  logic          md_start_div;

  // Youngest-match search per source operand, then stall/forward decision.
  always_comb begin
    src[0]  = d_rs;
    src[1]  = d_rt;
    tuse[0] = d_tuse_rs;
    tuse[1] = d_tuse_rt;
    for (int s = 0; s < 2; s++) begin
      found[s]  = 1'b0;
      hit_k[s]  = '0;
      hit_t[s]  = '0;
      // Scan oldest to youngest so the lowest-k match is the one left standing.
      for (int k = STAGES; k >= 1; k--) begin
        if (wen_q[k-1] && (dst_q[k-1] == src[s]) && (src[s] != '0)) begin
          found[s] = 1'b1;
          hit_k[s] = SW'(k);
          hit_t[s] = tnew_q[k-1];
        end
      end
      op_stall[s] = found[s] && !(&tuse[s]) && (hit_t[s] > tuse[s]);
      op_sel[s]   = (found[s] && (hit_t[s] == '0)) ? hit_k[s] : '0;
    end
  end

  // hi/lo access must wait for the md unit, including a start sitting in E.
  always_comb begin
    md_stall      = d_md_use && ((md_cnt_q != '0) || md_flag_q);
    stall         = (|op_stall) || md_stall;
    md_start_mult = !stall && (d_md_start == 2'b01);
    md_start_div  = !stall && (d_md_start == 2'b10);
  end

  assign fwd_rs_sel = op_sel[0];
  assign fwd_rt_sel = op_sel[1];
  assign md_busy    = (md_cnt_q != '0);

  // Advance records one stage per cycle and run the md busy counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wen_q     <= '0;
      md_flag_q <= 1'b0;
      md_cnt_q  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        dst_q[k]  <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        wen_q[k]  <= wen_q[k-1];
        dst_q[k]  <= dst_q[k-1];
        tnew_q[k] <= (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
      end
      if (stall) begin
        wen_q[0]  <= 1'b0;
        dst_q[0]  <= '0;
        tnew_q[0] <= '0;
      end else begin
        wen_q[0]  <= d_wen;
        dst_q[0]  <= d_dst;
        tnew_q[0] <= d_tnew;
      end
      md_flag_q <= md_start_mult || md_start_div;
      if (md_start_mult) begin
        md_cnt_q <= MDW'(MULT_CYC);
      end else if (md_start_div) begin
        md_cnt_q <= MDW'(DIV_CYC);
      end else if (md_cnt_q != '0) begin
        md_cnt_q <= md_cnt_q - MDW'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: directed pipeline scenarios followed by random traffic,
// each cycle compared against a record-list model of the tracker.
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] d_rs, d_rt, d_dst;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew, d_md_start;
  logic       d_wen, d_md_use;
  logic       stall, md_busy;
  logic [1:0] fwd_rs_sel, fwd_rt_sel;

  int n_vec = 0;
  int n_err = 0;

  // Model: record k holds the Tnew it entered E with; its age gives the rest.
  int m_wen [1:3];
  int m_dst [1:3];
  int m_tin [1:3];
  int m_rem;
  bit m_mdf;

  always #5 clk = ~clk;

  hazard_tracker dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wen(d_wen), .d_dst(d_dst), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_use(d_md_use),
    .stall(stall), .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .md_busy(md_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int cur_tnew(input int k);
    return (m_tin[k] > k - 1) ? m_tin[k] - (k - 1) : 0;
  endfunction

  function automatic void op_eval(input int src, input int tu, output bit s, output int f);
    s = 1'b0;
    f = 0;
    for (int k = 1; k <= 3; k++) begin
      if (m_wen[k] != 0 && m_dst[k] == src && src != 0) begin
        s = (tu != 3) && (cur_tnew(k) > tu);
        f = (cur_tnew(k) == 0) ? k : 0;
        return;
      end
    end
  endfunction

  function automatic void model_eval(output bit st, output int frs, output int frt);
    bit srs, srt, smd;
    op_eval(int'(d_rs), int'(d_tuse_rs), srs, frs);
    op_eval(int'(d_rt), int'(d_tuse_rt), srt, frt);
    smd = d_md_use && (m_rem > 0 || m_mdf);
    st  = srs || srt || smd;
  endfunction

  function automatic void model_clear();
    for (int k = 1; k <= 3; k++) begin
      m_wen[k] = 0; m_dst[k] = 0; m_tin[k] = 0;
    end
    m_rem = 0;
    m_mdf = 1'b0;
  endfunction

  function automatic void model_update(input bit st);
    if (!reset) begin
      model_clear();
      return;
    end
    for (int k = 3; k >= 2; k--) begin
      m_wen[k] = m_wen[k-1]; m_dst[k] = m_dst[k-1]; m_tin[k] = m_tin[k-1];
    end
    m_wen[1] = st ? 0 : int'(d_wen);
    m_dst[1] = st ? 0 : int'(d_dst);
    m_tin[1] = st ? 0 : int'(d_tnew);
    m_mdf = !st && (d_md_start == 2'b01 || d_md_start == 2'b10);
    if (!st && d_md_start == 2'b01)      m_rem = 5;
    else if (!st && d_md_start == 2'b10) m_rem = 10;
    else if (m_rem > 0)                  m_rem--;
  endfunction

  // Compare against the model, then advance one clock.
  task automatic tick();
    bit e_st;
    int e_rs, e_rt;
    #1;
    model_eval(e_st, e_rs, e_rt);
    chk("model_stall", 32'(stall), 32'(e_st));
    chk("model_fwd_rs", 32'(fwd_rs_sel), 32'(e_rs));
    chk("model_fwd_rt", 32'(fwd_rt_sel), 32'(e_rt));
    chk("model_md_busy", 32'(md_busy), 32'(m_rem > 0));
    @(posedge clk);
    model_update(e_st);
    @(negedge clk);
  endtask

  task automatic set_d(input int wen, input int dst, input int tn, input int rs, input int tur,
                       input int rt, input int tut, input int mds, input int mdu);
    d_wen = 1'(wen); d_dst = 5'(dst); d_tnew = 2'(tn);
    d_rs = 5'(rs); d_tuse_rs = 2'(tur); d_rt = 5'(rt); d_tuse_rt = 2'(tut);
    d_md_start = 2'(mds); d_md_use = 1'(mdu);
  endtask

  task automatic nop();
    set_d(0, 0, 0, 0, 3, 0, 3, 0, 0);
  endtask

  task automatic md_run(input string tag, input int kind, input int cyc);
    int busy_cnt, stall_cnt;
    bit released;
    busy_cnt = 0; stall_cnt = 0;
    set_d(0, 0, 0, 0, 3, 0, 3, kind, 1);
    tick();
    set_d(1, 5, 1, 0, 3, 0, 3, 0, 1);
    for (int i = 0; i < 20; i++) begin
      #1;
      if (md_busy) busy_cnt++;
      if (stall) stall_cnt++;
      released = !stall;
      if (released) chk({tag, "_busy_at_release"}, 32'(md_busy), 32'd0);
      tick();
      if (released) break;
    end
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(cyc));
    chk({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(cyc));
    nop();
    tick();
  endtask

  initial begin
    bit held;
    nop();
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    model_clear();
    @(negedge clk);
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fwd_rs", 32'(fwd_rs_sel), 32'd0);
    chk("rst_fwd_rt", 32'(fwd_rt_sel), 32'd0);
    chk("rst_md_busy", 32'(md_busy), 32'd0);
    reset = 1'b1;
    tick();

    // lw $1 then addu $2,$1,$0: one stall, then no forward (W not reached yet).
    set_d(1, 1, 2, 0, 3, 0, 3, 0, 0);
    tick();
    set_d(1, 2, 1, 1, 1, 0, 1, 0, 0);
    #1 chk("lw_use_stall1", 32'(stall), 32'd1);
    tick();
    #1 chk("lw_use_stall2", 32'(stall), 32'd0);
    chk("lw_use_fwd2", 32'(fwd_rs_sel), 32'd0);
    tick();
    nop();
    tick(); tick(); tick();

    // ori $3 then beq $3: one stall, then forward from M.
    set_d(1, 3, 1, 0, 3, 0, 3, 0, 0);
    tick();
    set_d(0, 0, 0, 3, 0, 0, 0, 0, 0);
    #1 chk("beq_stall1", 32'(stall), 32'd1);
    tick();
    #1 chk("beq_stall2", 32'(stall), 32'd0);
    chk("beq_fwd_rs", 32'(fwd_rs_sel), 32'd2);
    tick();
    nop();
    tick(); tick(); tick();

    // Double write of $4: youngest (lw) decides, older addu must not forward.
    set_d(1, 4, 1, 0, 3, 0, 3, 0, 0);
    tick();
    set_d(1, 4, 2, 0, 3, 0, 3, 0, 0);
    tick();
    set_d(0, 0, 0, 4, 1, 0, 3, 0, 0);
    #1 chk("dbl_stall", 32'(stall), 32'd1);
    chk("dbl_fwd_rs", 32'(fwd_rs_sel), 32'd0);
    tick();
    tick();
    nop();
    tick(); tick(); tick();

    // Writes to $0 fill every stage; reading $0 never hazards.
    set_d(1, 0, 0, 0, 3, 0, 3, 0, 0);
    tick(); tick(); tick();
    set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("r0_stall", 32'(stall), 32'd0);
    chk("r0_fwd_rs", 32'(fwd_rs_sel), 32'd0);
    chk("r0_fwd_rt", 32'(fwd_rt_sel), 32'd0);
    tick();

    md_run("div", 2, 10);
    md_run("mult", 1, 5);

    // Reset during a div count of 4 with lw $1 in E.
    set_d(0, 0, 0, 0, 3, 0, 3, 2, 1);
    tick();
    nop();
    for (int i = 0; i < 5; i++) tick();
    set_d(1, 1, 2, 0, 3, 0, 3, 0, 0);
    tick();
    set_d(1, 6, 1, 1, 0, 0, 3, 0, 1);
    #1 chk("mid_pre_stall", 32'(stall), 32'd1);
    chk("mid_pre_busy", 32'(md_busy), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1 chk("mid_post_busy", 32'(md_busy), 32'd0);
    chk("mid_post_stall", 32'(stall), 32'd0);
    chk("mid_post_fwd_rs", 32'(fwd_rs_sel), 32'd0);
    chk("mid_post_fwd_rt", 32'(fwd_rt_sel), 32'd0);
    tick();

    // Random traffic; D inputs held while stalled.
    held = 1'b0;
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 49) != 0);
      if (!held || !reset) begin
        d_wen      = 1'($urandom_range(0, 1));
        d_dst      = 5'($urandom_range(0, 3));
        d_tnew     = 2'($urandom_range(0, 2));
        d_rs       = 5'($urandom_range(0, 3));
        d_rt       = 5'($urandom_range(0, 3));
        d_tuse_rs  = 2'($urandom_range(0, 3));
        d_tuse_rt  = 2'($urandom_range(0, 3));
        d_md_start = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        d_md_use   = (d_md_start != 2'b00) || ($urandom_range(0, 5) == 0);
      end
      #1 held = stall;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
# hazard_tracker

Parametrised stall/forward controller for the MIPS pipeline. It holds a shift register of in-flight destination records (write-enable, destination register, Tnew) for every stage after D. It also runs a cycle counter for the multiply/divide unit. Each cycle it tells D whether to stall and which stage, if any, forwards each source operand. It generalises the per-stage combinational Tnew/WriteReg decode into one sequential block that works for any stage count.

## Interface
- STAGES, 3, tracked stages after D; stage 1 = E (youngest), stage STAGES = oldest (W)
- AW, 5, register address width
- TW, 2, Tnew/Tuse width
- MULT_CYC, 5, busy cycles after a mult/multu enters E
- DIV_CYC, 10, busy cycles after a div/divu enters E
- SW, $clog2(STAGES+1), forward-select width

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-low; one clock, one reset, fixed
- d_rs, d_rt  in  AW each  D-stage source registers
- d_tuse_rs, d_tuse_rt  in  TW each  cycles until the operand is consumed; all-ones = operand unused
- d_wen  in  1  D instruction writes the GRF
- d_dst  in  AW  D destination register
- d_tnew  in  TW  Tnew the instruction carries on entry to E
- d_md_start  in  2  00 none, 01 mult/multu, 10 div/divu, 11 reserved (treated as 00)
- d_md_use  in  1  D reads or writes hi/lo (mfhi/mflo/mthi/mtlo/mult/div)
- stall  out  1  hold PC and the D register; inject a bubble into E
- fwd_rs_sel, fwd_rt_sel  out  SW each  0 = GRF, k = stage k result
- md_busy  out  1  md counter non-zero

## Operation
- Record k holds {wen_k, dst_k, tnew_k}. A record is a match for source s when wen_k=1, dst_k=s and s≠0.
- Youngest match rule: only the lowest-k match is considered. Older matches are stale and are ignored.
- Stall on operand: the youngest match has tnew_k > tuse. An unused operand (tuse all-ones) never stalls.
- Stall on md: d_md_use=1 and (md_busy=1 or record 1 carries an md start).
- stall = rs_stall | rt_stall | md_stall. It is combinational from the records and D inputs.
- fwd_sel = k when the youngest match has tnew_k = 0. Otherwise fwd_sel = 0, including when there is no match.
- Shift each cycle when reset=1:
  - record k+1 ← record k with tnew saturating-decremented (0 stays 0);
  - record 1 ← {d_wen, d_dst, d_tnew} if stall=0, else a bubble {0,0,0};
  - the oldest record is discarded.
- md counter: when stall=0 and d_md_start=01, load MULT_CYC on the same edge record 1 is loaded; 10 loads DIV_CYC.
- Otherwise the md counter decrements while non-zero.
- A new start while busy cannot occur because md_stall blocks it. If it occurs anyway, the reload wins.
- The md-start flag travels with record 1 only, for the E-stage check.
- d_dst=0 with d_wen=1 is stored but never matches.

## Timing
- Reset (reset=0 at an edge): all records become bubbles and the md counter = 0. Next cycle: stall=0, fwd_*_sel=0, md_busy=0.
- Reset asserted mid-operation discards all in-flight records and any md count with no residual stall.
- Record latency: a D instruction accepted at edge n is in record 1 during cycle n+1 and in record k during cycle n+k.
- Tnew example: lw enters with 2. It reads 2 in E, 1 in M, 0 in W.
- md_busy rises the cycle after the start is accepted and stays high exactly MULT_CYC or DIV_CYC cycles.
- Simultaneous rs and rt hazards are evaluated independently, and stall is their OR.
- Stall held N cycles inserts N bubbles. The D inputs must stay stable and are re-evaluated every cycle.

## Test plan
- lw $1 accepted, then D = addu $2,$1,$0 (tuse_rs=1):
  - cycle 1 stall=1;
  - cycle 2 stall=0, fwd_rs_sel=0;
  - following cycles: the bubble propagates with wen=0.
- ori $3 (tnew 1) accepted, then beq $3,$0 (tuse 0): stall=1 for one cycle. Next cycle fwd_rs_sel=2 and stall=0.
- Double write: addu $4 at record 2 (tnew 0) and lw $4 at record 1 (tnew 2), D reads $4 with tuse 1 → stall=1. fwd_rs_sel must not select 2.
- $0: jal-style records with dst=0 in all stages, D reads $0 → stall=0, fwd=0.
- div accepted, D = mflo next → md_busy high 10 cycles. stall=1 through the last busy cycle, released the cycle md_busy=0. Repeat with mult for 5 cycles.
- reset=0 during a div count at 4 with a lw in record 1 → next cycle md_busy=0, stall=0, all fwd_sel=0.
